// File: rtl/level_pkg.sv
// Shared level data: block geometry, platform entry layout, loader states and
// the seven block layouts served by platform_rom.
package level_pkg;
    localparam int PHY_WIDTH    = 14;
    localparam int LEN_WIDTH    = 4;
    localparam int BLOCK_NUM    = 7;
    localparam int PLAT_NUM     = 7;
    localparam int BLOCK_HEIGHT = 480;
    localparam int ROM_DEPTH    = BLOCK_NUM * PLAT_NUM;
    localparam int ROM_AW       = $clog2(ROM_DEPTH);

    typedef struct packed {
        logic [PHY_WIDTH-1:0] x;
        logic [PHY_WIDTH-1:0] y;
        logic [LEN_WIDTH-1:0] len;
    } plat_t;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOAD, S_COMMIT} ld_state_t;

    localparam plat_t DEFAULT_PLAT = '{x: '0, y: '0, len: LEN_WIDTH'(1)};

    localparam logic [PHY_WIDTH-1:0] LAYOUT_X [BLOCK_NUM][PLAT_NUM] = '{
        '{14'd16, 14'd96,  14'd176, 14'd256, 14'd336, 14'd416, 14'd496},
        '{14'd24, 14'd104, 14'd184, 14'd264, 14'd344, 14'd424, 14'd504},
        '{14'd32, 14'd112, 14'd192, 14'd272, 14'd352, 14'd432, 14'd512},
        '{14'd40, 14'd120, 14'd200, 14'd280, 14'd360, 14'd440, 14'd520},
        '{14'd48, 14'd128, 14'd208, 14'd288, 14'd368, 14'd448, 14'd528},
        '{14'd56, 14'd136, 14'd216, 14'd296, 14'd376, 14'd456, 14'd536},
        '{14'd64, 14'd144, 14'd224, 14'd304, 14'd384, 14'd464, 14'd544}};

    // y is relative to the block base; platforms descend from near the top.
    localparam logic [PHY_WIDTH-1:0] LAYOUT_Y [BLOCK_NUM][PLAT_NUM] = '{
        '{14'd460, 14'd396, 14'd332, 14'd268, 14'd204, 14'd140, 14'd76},
        '{14'd458, 14'd394, 14'd330, 14'd266, 14'd202, 14'd138, 14'd74},
        '{14'd456, 14'd392, 14'd328, 14'd264, 14'd200, 14'd136, 14'd72},
        '{14'd454, 14'd390, 14'd326, 14'd262, 14'd198, 14'd134, 14'd70},
        '{14'd452, 14'd388, 14'd324, 14'd260, 14'd196, 14'd132, 14'd68},
        '{14'd450, 14'd386, 14'd322, 14'd258, 14'd194, 14'd130, 14'd66},
        '{14'd448, 14'd384, 14'd320, 14'd256, 14'd192, 14'd128, 14'd64}};

    localparam logic [LEN_WIDTH-1:0] LAYOUT_LEN [BLOCK_NUM][PLAT_NUM] = '{
        '{4'd4,  4'd5,  4'd6,  4'd7,  4'd8,  4'd9,  4'd10},
        '{4'd5,  4'd6,  4'd7,  4'd8,  4'd9,  4'd10, 4'd11},
        '{4'd6,  4'd7,  4'd8,  4'd9,  4'd10, 4'd11, 4'd4},
        '{4'd7,  4'd8,  4'd9,  4'd10, 4'd11, 4'd4,  4'd5},
        '{4'd8,  4'd9,  4'd10, 4'd11, 4'd4,  4'd5,  4'd6},
        '{4'd9,  4'd10, 4'd11, 4'd4,  4'd5,  4'd6,  4'd7},
        '{4'd10, 4'd11, 4'd4,  4'd5,  4'd6,  4'd7,  4'd8}};

    function automatic plat_t rom_entry(input logic [ROM_AW-1:0] addr);
        rom_entry = DEFAULT_PLAT;
        for (int b = 0; b < BLOCK_NUM; b++)
            for (int k = 0; k < PLAT_NUM; k++)
                if (int'(addr) == b * PLAT_NUM + k)
                    rom_entry = '{x: LAYOUT_X[b][k], y: LAYOUT_Y[b][k], len: LAYOUT_LEN[b][k]};
    endfunction
endpackage

// File: rtl/platform_rom.sv
// Synchronous platform ROM, one-cycle read latency; addresses past the last
// layout return the default entry.
module platform_rom
    import level_pkg::*;
(
    input  logic                              sys_clk,
    input  logic                              sys_rst_n,
    input  logic [ROM_AW-1:0]                 addr,
    output logic [2*PHY_WIDTH+LEN_WIDTH-1:0]  data
);
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) data <= '0;
        else            data <= rom_entry(addr);
    end
endmodule

// File: rtl/block_stream_gen.sv
// Tracks the character's vertical block and streams that block's platform
// layout from ROM into a shadow bank, committing it atomically.
module block_stream_gen #(
    parameter int BLOCK_NUM    = 7,
    parameter int PLAT_NUM     = 7,
    parameter int PHY_WIDTH    = 14,
    parameter int BLOCK_HEIGHT = 480,
    parameter int HYST         = 16,
    parameter int LEN_WIDTH    = 4,
    parameter int IDX_WIDTH    = 5
) (
    input  logic                              sys_clk,
    input  logic                              sys_rst_n,
    input  logic signed [PHY_WIDTH:0]         abs_char_y,
    output logic [IDX_WIDTH-1:0]              camera_y,
    output logic [$clog2(BLOCK_NUM)-1:0]      cur_block_type,
    output logic signed [PHY_WIDTH:0]         char_rel_y,
    output logic [PLAT_NUM*PHY_WIDTH-1:0]     plat_x,
    output logic [PLAT_NUM*PHY_WIDTH-1:0]     plat_y,
    output logic [PLAT_NUM*LEN_WIDTH-1:0]     plat_len,
    output logic                              tbl_valid,
    output logic                              load_done,
    output logic                              block_switch,
    output logic                              switch_up,
    output logic                              busy
);
    import level_pkg::*;

    localparam int TYPE_W  = $clog2(BLOCK_NUM);
    localparam int AW      = PHY_WIDTH + 2;
    localparam int MAX_IDX = 2**IDX_WIDTH - 1;
    localparam int KW      = $clog2(PLAT_NUM + 1);

    logic [AW-1:0]     y_pos, base, base_nxt;
    logic [TYPE_W-1:0] type_nxt, ld_type;
    logic              step_up, step_dn;
    ld_state_t         state;
    logic [KW-1:0]     k;
    logic [ROM_AW-1:0] rom_addr;
    plat_t             rom_q;
    plat_t             shadow [PLAT_NUM];

    assign y_pos   = abs_char_y[PHY_WIDTH] ? '0 : AW'(abs_char_y[PHY_WIDTH-1:0]);
    assign step_up = (y_pos >= base + AW'(BLOCK_HEIGHT)) && (camera_y != IDX_WIDTH'(MAX_IDX));
    // Hysteresis: the character must sink HYST below the base before stepping down.
    assign step_dn = !step_up && (y_pos + AW'(HYST) < base) && (camera_y != '0);

    always_comb begin
        base_nxt = base;
        type_nxt = cur_block_type;
        if (step_up) begin
            base_nxt = base + AW'(BLOCK_HEIGHT);
            type_nxt = (cur_block_type == TYPE_W'(BLOCK_NUM - 1)) ? '0 : cur_block_type + TYPE_W'(1);
        end else if (step_dn) begin
            base_nxt = base - AW'(BLOCK_HEIGHT);
            type_nxt = (cur_block_type == '0) ? TYPE_W'(BLOCK_NUM - 1) : cur_block_type - TYPE_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            camera_y       <= '0;
            base           <= '0;
            cur_block_type <= '0;
            block_switch   <= 1'b0;
            switch_up      <= 1'b0;
            char_rel_y     <= '0;
        end else begin
            base           <= base_nxt;
            cur_block_type <= type_nxt;
            block_switch   <= step_up || step_dn;
            char_rel_y     <= (PHY_WIDTH+1)'(y_pos - base_nxt);
            if (step_up) begin
                camera_y  <= camera_y + IDX_WIDTH'(1);
                switch_up <= 1'b1;
            end else if (step_dn) begin
                camera_y  <= camera_y - IDX_WIDTH'(1);
                switch_up <= 1'b0;
            end
        end
    end

    assign rom_addr = ROM_AW'(ld_type) * ROM_AW'(PLAT_NUM) + ROM_AW'(k);

    platform_rom u_rom (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .addr      (rom_addr),
        .data      (rom_q)
    );

    // A tracker step preempts every state, so a stale load never commits.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_INIT;
            k         <= '0;
            ld_type   <= '0;
            tbl_valid <= 1'b0;
            load_done <= 1'b0;
            busy      <= 1'b0;
            plat_x    <= '0;
            plat_y    <= '0;
            plat_len  <= '0;
            for (int i = 0; i < PLAT_NUM; i++) shadow[i] <= '0;
        end else begin
            load_done <= 1'b0;
            if (step_up || step_dn) begin
                state     <= S_LOAD;
                k         <= '0;
                ld_type   <= type_nxt;
                tbl_valid <= 1'b0;
                busy      <= 1'b1;
            end else begin
                case (state)
                    S_INIT: begin
                        state   <= S_LOAD;
                        k       <= '0;
                        ld_type <= '0;
                        busy    <= 1'b1;
                    end
                    S_LOAD: begin
                        if (k != '0) shadow[k - KW'(1)] <= rom_q;
                        if (k == KW'(PLAT_NUM)) state <= S_COMMIT;
                        else                    k     <= k + KW'(1);
                    end
                    S_COMMIT: begin
                        for (int i = 0; i < PLAT_NUM; i++) begin
                            plat_x[i*PHY_WIDTH +: PHY_WIDTH]   <= shadow[i].x;
                            plat_y[i*PHY_WIDTH +: PHY_WIDTH]   <= shadow[i].y;
                            plat_len[i*LEN_WIDTH +: LEN_WIDTH] <= shadow[i].len;
                        end
                        tbl_valid <= 1'b1;
                        load_done <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/block_stream_gen.md
Name: block_stream_gen

Overview:
- Successor block generator. Tracks which vertical block the character is in, using incremental block-boundary tracking (no divider) with hysteresis on downward switches.
- Streams the current block's platform layout out of a synchronous platform ROM into a shadow bank, then commits it atomically to the flattened platform outputs.
- Sits between the physics core (supplies abs_char_y) and the collision/VGA render blocks (consume the platform table and camera index).

Parameters:
- BLOCK_NUM, 7: distinct block layouts; type index wraps modulo this.
- PLAT_NUM, 7: platforms per block.
- PHY_WIDTH, 14: physical coordinate width.
- BLOCK_HEIGHT, 480: vertical span of one block.
- HYST, 16: extra descent below the block base required before stepping down.
- LEN_WIDTH, 4: platform length field width.
- IDX_WIDTH, 5: block index width; MAX_IDX = 2**IDX_WIDTH-1.

Ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  reset.
- abs_char_y  in  PHY_WIDTH+1 (signed)  absolute character height.
- camera_y  out  IDX_WIDTH  current block index.
- cur_block_type  out  clog2(BLOCK_NUM)  layout index = camera_y mod BLOCK_NUM.
- char_rel_y  out  PHY_WIDTH+1 (signed)  clamped y minus block base, registered.
- plat_x  out  PLAT_NUM*PHY_WIDTH  flattened platform x; entry i at [i*PHY_WIDTH +: PHY_WIDTH].
- plat_y  out  PLAT_NUM*PHY_WIDTH  flattened platform y, relative to block base.
- plat_len  out  PLAT_NUM*LEN_WIDTH  flattened platform lengths.
- tbl_valid  out  1  platform outputs match cur_block_type.
- load_done  out  1  one-cycle pulse on commit.
- block_switch  out  1  one-cycle pulse per index step.
- switch_up  out  1  direction of last step (1 = up).
- busy  out  1  loader not idle.

Behaviour:
- Reset (sys_rst_n, asynchronous, active-low; clock sys_clk): all outputs are 0, block_base = 0, loader in S_INIT.
- Clamp: y_pos = 0 if abs_char_y < 0, else abs_char_y.
- Tracker: at most one step per cycle, evaluated in priority order.
  - Up: if y_pos >= base+BLOCK_HEIGHT and camera_y < MAX_IDX, then camera_y+1, base += BLOCK_HEIGHT, type+1 (wraps BLOCK_NUM-1 -> 0), block_switch=1, switch_up=1.
  - Down: else if y_pos+HYST < base and camera_y > 0, then camera_y-1, base -= BLOCK_HEIGHT, type-1 (wraps 0 -> BLOCK_NUM-1), block_switch=1, switch_up=0.
  - Otherwise: block_switch=0 and switch_up holds its value.
  - Large jumps converge one block per cycle, with one pulse per step.
  - At MAX_IDX the index saturates: no step, no pulse.
- char_rel_y: registered y_pos - base, computed from the post-step base. It may go negative by up to HYST.
- Arithmetic: base compares use PHY_WIDTH+2 bits, so there is no wrap.
- Loader FSM states: S_INIT, S_IDLE, S_LOAD, S_COMMIT.
  - S_INIT: goes to S_LOAD (type 0, k=0) one cycle after reset release.
  - Any tracker step, in any state: tbl_valid <= 0 and the FSM goes to S_LOAD with k=0 and the new type. A load in progress is aborted and nothing partial is committed.
  - S_LOAD: ROM address = type*PLAT_NUM+k while k < PLAT_NUM. ROM latency is 1 cycle, so shadow[k-1] is written when k > 0. When k == PLAT_NUM, shadow[PLAT_NUM-1] is written and the FSM goes to S_COMMIT.
  - S_COMMIT: copies shadow to plat_x/plat_y/plat_len, sets tbl_valid=1, pulses load_done, goes to S_IDLE.
  - Latency: load_done is high PLAT_NUM+2 cycles after the block_switch pulse (9 at defaults).
- During a load the previous table is held stable with tbl_valid=0; platform outputs only change at commit.
- busy = state != S_IDLE.
- A step arriving in the same cycle as S_COMMIT wins: no commit occurs and the load restarts.

Decomposition:
- Shared package level_pkg holds:
  - BLOCK_HEIGHT and PLAT_NUM constants;
  - the platform entry struct {x, y, len};
  - the seven block layouts as constant arrays;
  - the default layout, used for out-of-range types.
- One sub-module, platform_rom: synchronous-read ROM, 1-cycle latency, address clog2(BLOCK_NUM*PLAT_NUM) bits, data 2*PHY_WIDTH+LEN_WIDTH bits. Contents come from level_pkg; unmapped addresses return the default layout.

Test Plan:
- Reset release, y=0 -> camera_y=0, type 0; load_done 9 cycles after S_INIT exit; tbl_valid=1; plat entries equal layout 0.
- y ramps 470->485 -> single block_switch pulse at y=480, switch_up=1, camera_y=1, char_rel_y=5; tbl_valid low until reload commits layout 1.
- From idx 1 base 480, y=470 -> no step; y=463 -> step down, switch_up=0, camera_y=0.
- y jumps 0->1500 in one cycle -> three consecutive block_switch pulses, camera_y=3, type 3; exactly one load_done, 9 cycles after the last pulse.
- Step at k=3 of a load -> abort; no load_done for the old type; outputs keep the prior table until the new commit.
- Climb to camera_y=7 -> type wraps to 0; y=-50 -> clamped to 0, no underflow. At camera_y=MAX_IDX with y above its top -> no pulse.
